// File: rtl/pingpong_frame_capture_pkg.sv
// Shared state encoding, default sizes and address-width helper for the
// ping-pong frame capture block.
package pingpong_frame_capture_pkg;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    IDLE    = 3'd1,
    COPY    = 3'd2,
    START   = 3'd3,
    PROCESS = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FRAME_SIZE = 64;
  localparam int DEF_HOP_SIZE   = 64;

  // Ring buffer holds two frames so a copy can run while new samples land.
  function automatic int addr_w(input int frame_size);
    return $clog2(2 * frame_size);
  endfunction

endpackage

// File: rtl/pingpong_frame_capture_frame_ram.sv
// Single-port sample RAM: one access per cycle, registered read data.
module frame_ram
  import pingpong_frame_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = addr_w(DEF_FRAME_SIZE)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pingpong_frame_capture.sv
// Captures ADC samples into a ring RAM and every HOP_SIZE samples copies the
// newest FRAME_SIZE samples into a flat frame register for the processor.
//
// state   | meaning
// FILL    | priming: fewer than FRAME_SIZE samples written since reset
// IDLE    | waiting for the next hop dispatch
// COPY    | reading the frame out of RAM into the frame register
// START   | one-cycle proc_start pulse
// PROCESS | processor running; proc_done ignored on the first cycle
module pingpong_frame_capture
  import pingpong_frame_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int HOP_SIZE   = DEF_HOP_SIZE,
  parameter int DROP_W     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            sample,
  input  logic                             eoc,
  output logic [FRAME_SIZE*DATA_WIDTH-1:0] frame,
  output logic                             proc_start,
  input  logic                             proc_done,
  output logic                             busy,
  output logic                             overrun,
  output logic [DROP_W-1:0]                drop_count
);

  localparam int AW = addr_w(FRAME_SIZE);
  localparam int LW = $clog2(FRAME_SIZE);
  localparam int HW = $clog2(HOP_SIZE) + 1;

  localparam logic [AW-1:0] PRIME_LAST = AW'(FRAME_SIZE - 1);
  localparam logic [HW-1:0] HOP_LAST   = HW'(HOP_SIZE - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(FRAME_SIZE - 1);

  logic            eoc_s1, eoc_s2, eoc_d;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr;
  logic            primed;
  logic [HW-1:0]   hop_cnt;
  logic            dispatch;
  state_t          state;
  logic [AW-1:0]   base;
  logic [LW:0]     rd_idx;
  logic            rd_issue;
  logic            rd_valid;
  logic [LW-1:0]   copy_idx;
  logic            proc_first;
  logic [AW-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_en    = eoc_s2 & ~eoc_d;
  assign dispatch = wr_en && (primed ? (hop_cnt == HOP_LAST) : (wr_ptr == PRIME_LAST));
  // Capture writes win the single RAM port; the copy read simply retries.
  assign rd_issue = (state == COPY) && !rd_idx[LW] && !wr_en;
  assign ram_addr = wr_en ? wr_ptr : base + AW'(rd_idx[LW-1:0]);
  assign busy     = (state == COPY) || (state == START) || (state == PROCESS);

  frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (sample),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      eoc_s1     <= 1'b0;
      eoc_s2     <= 1'b0;
      eoc_d      <= 1'b0;
      wr_ptr     <= '0;
      primed     <= 1'b0;
      hop_cnt    <= '0;
      state      <= FILL;
      base       <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      copy_idx   <= '0;
      proc_first <= 1'b0;
      frame      <= '0;
      proc_start <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      eoc_s1   <= eoc;
      eoc_s2   <= eoc_s1;
      eoc_d    <= eoc_s2;
      rd_valid <= rd_issue;

      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!primed && wr_ptr == PRIME_LAST) primed <= 1'b1;
        if (primed) hop_cnt <= (hop_cnt == HOP_LAST) ? '0 : hop_cnt + 1'b1;
      end

      if (rd_issue) rd_idx <= rd_idx + 1'b1;

      case (state)
        FILL: if (primed) state <= IDLE;
        COPY: begin
          if (rd_valid) begin
            frame[int'(copy_idx)*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
            copy_idx <= copy_idx + 1'b1;
            if (copy_idx == LANE_LAST) begin
              state      <= START;
              proc_start <= 1'b1;
            end
          end
        end
        START: begin
          proc_start <= 1'b0;
          proc_first <= 1'b1;
          state      <= PROCESS;
        end
        PROCESS: begin
          if (proc_first) proc_first <= 1'b0;
          else if (proc_done) state <= IDLE;
        end
        default: ;
      endcase

      // The priming write dispatches straight out of FILL.
      if (dispatch) begin
        if (state == IDLE || state == FILL) begin
          state    <= COPY;
          base     <= wr_ptr - PRIME_LAST;
          rd_idx   <= '0;
          copy_idx <= '0;
        end else begin
          overrun <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pingpong_frame_capture.md
# pingpong_frame_capture

Parametrised successor to the fixed 8-bit ping-pong audio capture in the pitch-detector top level. Captures ADC samples on `eoc` rising edges into a circular single-port RAM, and every `HOP_SIZE` samples copies the most recent `FRAME_SIZE` samples into a flat frame register. It then starts the downstream processor, such as the min-tau pitch core, with a start/done handshake. It adds frame overlap, a collision-safe RAM port arbiter, an input synchroniser, and overrun detection with a drop counter.

## Interface
- `DATA_WIDTH`, 8: sample width in bits.
- `FRAME_SIZE`, 64: samples per frame; power of two, ≥ 4.
- `HOP_SIZE`, 64: new samples between frame dispatches; 1 ≤ `HOP_SIZE` ≤ `FRAME_SIZE`.
- `DROP_W`, 8: drop counter width.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sample` in `DATA_WIDTH`: ADC parallel data; stable while `eoc` is high and for ≥ 3 `clk` cycles after the `eoc` rise.
- `eoc` in 1: ADC end-of-conversion; asynchronous; synchronised internally.
- `frame` out `FRAME_SIZE*DATA_WIDTH`: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 holds the oldest sample.
- `proc_start` out 1: one-cycle start pulse to the processor.
- `proc_done` in 1: processor ready level.
- `busy` out 1: high in COPY, START and PROCESS.
- `overrun` out 1: sticky; set when a frame is dropped.
- `drop_count` out `DROP_W`: number of dropped frames; saturates at all-ones.

## Operation
- **Capture**
  - `eoc` passes through a 2-flop synchroniser, then a rising-edge detector.
  - Each detected edge produces exactly one RAM write of `sample` at `wr_ptr`, then `wr_ptr` increments.
  - RAM depth is 2*`FRAME_SIZE`; pointers wrap by truncation.
  - `eoc` held high for any duration produces one write.
- **Priming**
  - `primed` is set once `FRAME_SIZE` samples have been written since reset.
  - No dispatch occurs before `primed` is set.
  - The first dispatch happens on the write that sets `primed`.
- **Hop counter**
  - Counts writes after priming.
  - On reaching `HOP_SIZE` it resets to 0 and raises a dispatch request.
- **Dispatch**
  - If the request arrives in IDLE: `base` = `wr_ptr` (post-increment) − `FRAME_SIZE`, then go to COPY.
  - If the request arrives in any other state: the frame is dropped, `overrun` is set to 1, `drop_count` increments (saturating), and the state is unchanged.
- **States**
  - FILL → IDLE when `primed` is set.
  - IDLE → COPY on a dispatch request.
  - COPY reads addresses `base`…`base+FRAME_SIZE−1` (mod depth). Each datum returning from the RAM (1-cycle registered read) is written into lane `copy_idx`. After the last lane is written, go to START.
  - START: `proc_start` = 1 for this one cycle, then PROCESS.
  - PROCESS:
    - `proc_done` is ignored on the first cycle, because the processor may still report done from the previous frame.
    - From the second cycle on, `proc_done` = 1 → IDLE.
- **Port arbitration**
  - A capture write has priority over a copy read in the same cycle.
  - On a collision the read is not issued, the read address holds, and the copy stalls one cycle.
  - A read-valid flag tracks which RAM outputs are real data.
- **Frame register**
  - Modified only in COPY.
  - Stable from START until the next COPY.

## Timing
- **Reset values**
  - All outputs 0, including `frame`.
  - State = FILL; `wr_ptr`, hop counter and `primed` cleared.
  - The synchroniser flops are cleared.
- **Capture latency:** the write occurs on the 3rd `clk` edge after the `eoc` rise.
- **Dispatch latency:** COPY begins the cycle after the dispatching write.
- **COPY duration:** `FRAME_SIZE`+1 cycles, plus 1 per colliding write.
- **Dispatch to `proc_start`:** `FRAME_SIZE`+2 cycles when there are no stalls.
- **Minimum PROCESS duration:** 2 cycles.
- **Overlap safety:** new writes cannot reach `base` until `FRAME_SIZE` further samples arrive. The design requires the `clk`/sample-rate ratio to exceed 2*`FRAME_SIZE`.
- **Reset mid-operation:** abandons the copy or processing; no `proc_start` follows. A full re-prime is required.
- **`HOP_SIZE` = `FRAME_SIZE`:** gives plain ping-pong behaviour with no overlap.

## Structure
- **Shared constants package**
  - State encodings: FILL=0, IDLE=1, COPY=2, START=3, PROCESS=4.
  - Default `DATA_WIDTH`, `FRAME_SIZE`, `HOP_SIZE`.
  - Address-width function: $clog2(2*`FRAME_SIZE`).
- **Sub-module `frame_ram`:** single-port RAM with registered read, one write per cycle, parametrised depth and width.
- **Top of block:** synchroniser, edge detector, FSM, arbiter and frame register.

## Test plan
- **Priming** (`FRAME_SIZE`=8, `HOP_SIZE`=4): eoc edges with samples 1..8.
  - `proc_start` pulses once, 10 cycles after the 8th write.
  - `frame` lanes 0..7 = 1..8.
- **Overlap:** `proc_done`=1 after the first frame, then samples 9..12.
  - Second frame lanes = 5..12.
  - `drop_count`=0.
- **Overrun:** hold `proc_done`=0 and feed samples 13..16.
  - No `proc_start`.
  - `overrun`=1, `drop_count`=1.
  - `frame` unchanged.
- **Collision:** an eoc edge lands during COPY.
  - COPY lasts 10 cycles instead of 9.
  - Lanes are still the correct consecutive samples.
- **Stale done and edge detect:** `proc_done` tied to 1 and `eoc` held high for 20 cycles.
  - PROCESS lasts exactly 2 cycles.
  - The 20-cycle `eoc` pulse writes only one sample.
- **Reset mid-COPY:**
  - Next cycle: all outputs are 0 and the state is FILL.
  - The next `proc_start` needs 8 fresh samples.
